// File: rtl/axicb_prio_rr_arbiter_if.sv
// Arbitration bus between a group of requesters and one priority
// round-robin arbiter.
//
// Signals:
//   en        enable; downstream can accept a new transfer
//   req       one request bit per requester
//   prio      packed priorities, requester i in [i*PRIO_W +: PRIO_W]
//   done      the currently locked transfer completes this cycle
//   grant     one-hot grant, or all-zero
//   grant_id  binary index of the granted requester, 0 when no grant
//   busy      arbiter is holding a locked grant
//
// Modports:
//   master  requester side, drives en/req/prio/done
//   slave   arbiter side, drives grant/grant_id/busy
interface axicb_prio_rr_arbiter_if #(
    parameter int REQ_NB = 4,
    parameter int PRIO_W = 2,
    parameter int ID_W   = 2
);
    logic                     en;
    logic [REQ_NB-1:0]        req;
    logic [REQ_NB*PRIO_W-1:0] prio;
    logic                     done;
    logic [REQ_NB-1:0]        grant;
    logic [ID_W-1:0]          grant_id;
    logic                     busy;

    modport master (
        output en, req, prio, done,
        input  grant, grant_id, busy
    );

    modport slave (
        input  en, req, prio, done,
        output grant, grant_id, busy
    );
endinterface

// File: rtl/axicb_prio_rr_arbiter.sv
// Priority-layered round-robin arbiter with transaction locking.
//
// The highest priority present among the active requests selects a layer.
// Inside that layer a per-layer rotation mask gives fairness. A grant is
// issued combinationally in IDLE and then held in LOCKED until done.
//
// Ports:
//   aclk   clock, rising edge
//   srst   synchronous reset, active-high
//   arb    arbitration bus (slave modport): en, req, prio, done in;
//          grant, grant_id, busy out
module axicb_prio_rr_arbiter #(
    parameter int REQ_NB  = 4,
    parameter int PRIO_NB = 4,
    parameter int PRIO_W  = (PRIO_NB > 1) ? $clog2(PRIO_NB) : 1,
    parameter int ID_W    = (REQ_NB > 1) ? $clog2(REQ_NB) : 1
) (
    input  logic                      aclk,
    input  logic                      srst,
    axicb_prio_rr_arbiter_if.slave    arb
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [REQ_NB-1:0]  grant_q, grant_d;
    logic [REQ_NB-1:0]  mask_q [PRIO_NB];
    logic [REQ_NB-1:0]  mask_d [PRIO_NB];

    logic [PRIO_W-1:0]  eff_prio [REQ_NB];
    logic [PRIO_W-1:0]  layer;
    logic               any_req;
    logic [REQ_NB-1:0]  req_layer;
    logic [REQ_NB-1:0]  masked;
    logic [ID_W-1:0]    win_idx;
    logic [REQ_NB-1:0]  win_onehot;
    logic [REQ_NB-1:0]  next_mask;

    logic [REQ_NB-1:0]  grant_o;
    logic [ID_W-1:0]    grant_id_o;
    logic               busy_o;

    // Winner selection: clamp priorities, find the top active layer, then
    // pick the lowest index above the layer's rotation point, wrapping to
    // the lowest requester of the layer when nothing is left above it.
    always_comb begin
        any_req    = |arb.req;
        layer      = '0;
        req_layer  = '0;
        win_idx    = '0;
        win_onehot = '0;
        next_mask  = '0;

        for (int i = 0; i < REQ_NB; i++) begin
            eff_prio[i] = arb.prio[i*PRIO_W +: PRIO_W];
            if (int'(eff_prio[i]) >= PRIO_NB) begin
                eff_prio[i] = PRIO_W'(PRIO_NB - 1);
            end
        end

        for (int i = 0; i < REQ_NB; i++) begin
            if (arb.req[i] && (eff_prio[i] > layer)) begin
                layer = eff_prio[i];
            end
        end

        for (int i = 0; i < REQ_NB; i++) begin
            req_layer[i] = arb.req[i] && (eff_prio[i] == layer);
        end

        masked = req_layer & mask_q[layer];

        // Scanning downward leaves the lowest set index in win_idx.
        for (int i = REQ_NB - 1; i >= 0; i--) begin
            if ((masked != '0) ? masked[i] : req_layer[i]) begin
                win_idx = ID_W'(i);
            end
        end

        win_onehot[win_idx] = 1'b1;

        // Next rotation point: everything strictly above the winner; once
        // the top requester has been served the whole layer is eligible.
        for (int i = 0; i < REQ_NB; i++) begin
            next_mask[i] = (i > int'(win_idx));
        end
        if (int'(win_idx) == REQ_NB - 1) begin
            next_mask = '1;
        end
    end

    // Next-state and output logic. Only IDLE arbitrates; LOCKED replays the
    // captured grant and ignores the request side until done.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        mask_d  = mask_q;
        grant_o = '0;
        busy_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb.en && any_req) begin
                    grant_o        = win_onehot;
                    grant_d        = win_onehot;
                    mask_d[layer]  = next_mask;
                    state_d        = arb.done ? IDLE : LOCKED;
                end
            end
            LOCKED: begin
                grant_o = grant_q;
                busy_o  = 1'b1;
                if (arb.done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Binary encoding of the one-hot grant.
    always_comb begin
        grant_id_o = '0;
        for (int i = 0; i < REQ_NB; i++) begin
            if (grant_o[i]) begin
                grant_id_o = ID_W'(i);
            end
        end
    end

    // State, captured grant and per-layer masks; reset also aborts a lock.
    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q <= IDLE;
            grant_q <= '0;
            for (int l = 0; l < PRIO_NB; l++) begin
                mask_q[l] <= '1;
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            mask_q  <= mask_d;
        end
    end

    assign arb.grant    = grant_o;
    assign arb.grant_id = grant_id_o;
    assign arb.busy     = busy_o;

endmodule

// File: tb/tb_axicb_prio_rr_arbiter.sv
// Directed bench for axicb_prio_rr_arbiter (REQ_NB=4, PRIO_NB=4).
// Inputs change on the falling edge; the combinational grant is checked
// shortly afterwards, before the next rising edge commits it.
module tb_axicb_prio_rr_arbiter;

    localparam int REQ_NB  = 4;
    localparam int PRIO_NB = 4;
    localparam int PRIO_W  = 2;
    localparam int ID_W    = 2;

    logic aclk;
    logic srst;

    int compared   = 0;
    int mismatched = 0;

    axicb_prio_rr_arbiter_if #(
        .REQ_NB (REQ_NB),
        .PRIO_W (PRIO_W),
        .ID_W   (ID_W)
    ) bus ();

    axicb_prio_rr_arbiter #(
        .REQ_NB  (REQ_NB),
        .PRIO_NB (PRIO_NB),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W)
    ) dut (
        .aclk (aclk),
        .srst (srst),
        .arb  (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Drive one cycle of inputs on the falling edge.
    task automatic applyStimulus(input logic rst, input logic en,
                                 input logic [3:0] req, input logic [7:0] prio,
                                 input logic done);
        @(negedge aclk);
        srst     = rst;
        bus.en   = en;
        bus.req  = req;
        bus.prio = prio;
        bus.done = done;
    endtask

    task automatic checkOne(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_grant,
                               input logic [1:0] exp_id, input logic exp_busy);
        #1;
        checkOne({tag, ".grant"}, 32'(bus.grant), 32'(exp_grant));
        checkOne({tag, ".grant_id"}, 32'(bus.grant_id), 32'(exp_id));
        checkOne({tag, ".busy"}, 32'(bus.busy), 32'(exp_busy));
    endtask

    initial begin
        srst     = 1'b1;
        bus.en   = 1'b0;
        bus.req  = '0;
        bus.prio = '0;
        bus.done = 1'b0;

        // Reset, then idle outputs
        applyStimulus(1, 0, 4'b0000, 8'h00, 0);
        applyStimulus(0, 0, 4'b0000, 8'h00, 0);
        checkOutput("reset", 4'b0000, 2'd0, 0);

        // Fairness: full rotation and wrap
        applyStimulus(0, 1, 4'b1111, 8'h00, 1); checkOutput("fair0", 4'b0001, 2'd0, 0);
        applyStimulus(0, 1, 4'b1111, 8'h00, 1); checkOutput("fair1", 4'b0010, 2'd1, 0);
        applyStimulus(0, 1, 4'b1111, 8'h00, 1); checkOutput("fair2", 4'b0100, 2'd2, 0);
        applyStimulus(0, 1, 4'b1111, 8'h00, 1); checkOutput("fair3", 4'b1000, 2'd3, 0);
        applyStimulus(0, 1, 4'b1111, 8'h00, 1); checkOutput("fair4", 4'b0001, 2'd0, 0);

        // Skip of a non-requester, from fresh masks
        applyStimulus(1, 0, 4'b0000, 8'h00, 0);
        applyStimulus(0, 1, 4'b1101, 8'h00, 1); checkOutput("skip0", 4'b0001, 2'd0, 0);
        applyStimulus(0, 1, 4'b1101, 8'h00, 1); checkOutput("skip1", 4'b0100, 2'd2, 0);
        applyStimulus(0, 1, 4'b1101, 8'h00, 1); checkOutput("skip2", 4'b1000, 2'd3, 0);
        applyStimulus(0, 1, 4'b1101, 8'h00, 1); checkOutput("skip3", 4'b0001, 2'd0, 0);
        // mask 1110 -> winner 1, mask 1100; then wrap to 0, mask 1110
        applyStimulus(0, 1, 4'b0011, 8'h00, 1); checkOutput("skip4", 4'b0010, 2'd1, 0);
        applyStimulus(0, 1, 4'b0011, 8'h00, 1); checkOutput("wrap0", 4'b0001, 2'd0, 0);
        applyStimulus(0, 1, 4'b0011, 8'h00, 1); checkOutput("wrap1", 4'b0010, 2'd1, 0);

        // Priority: requester 2 at prio 3 dominates; layer-0 mask now 1100
        applyStimulus(0, 1, 4'b1111, 8'h30, 1); checkOutput("prio0", 4'b0100, 2'd2, 0);
        applyStimulus(0, 1, 4'b1111, 8'h30, 1); checkOutput("prio1", 4'b0100, 2'd2, 0);
        applyStimulus(0, 1, 4'b1111, 8'h30, 1); checkOutput("prio2", 4'b0100, 2'd2, 0);
        // Layer 0 resumes from its own mask 1100: 1011&1100 -> requester 3
        applyStimulus(0, 1, 4'b1011, 8'h30, 1); checkOutput("resume0", 4'b1000, 2'd3, 0);
        applyStimulus(0, 1, 4'b1011, 8'h30, 1); checkOutput("resume1", 4'b0001, 2'd0, 0);
        // Mixed layers: req0 prio1, req1 prio2 -> layer 2 wins
        applyStimulus(0, 1, 4'b0011, 8'h09, 1); checkOutput("layer", 4'b0010, 2'd1, 0);

        // Lock: layer-0 mask 1110, req 0010 -> winner 1, held while done=0
        applyStimulus(0, 1, 4'b0010, 8'h00, 0); checkOutput("lock0", 4'b0010, 2'd1, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 4'b1000, 8'h00, 0);
            checkOutput("lockhold", 4'b0010, 2'd1, 1);
        end
        applyStimulus(0, 1, 4'b1000, 8'h00, 1); checkOutput("lockdone", 4'b0010, 2'd1, 1);
        applyStimulus(0, 1, 4'b1000, 8'h00, 1); checkOutput("lockafter", 4'b1000, 2'd3, 0);

        // Reset mid-lock aborts the transfer and restores masks
        applyStimulus(0, 1, 4'b0001, 8'h00, 0); checkOutput("rlock0", 4'b0001, 2'd0, 0);
        applyStimulus(1, 1, 4'b1111, 8'h00, 0); checkOutput("rlock1", 4'b0001, 2'd0, 1);
        applyStimulus(0, 0, 4'b1111, 8'h00, 1); checkOutput("rlock2", 4'b0000, 2'd0, 0);
        applyStimulus(0, 1, 4'b1111, 8'h00, 1); checkOutput("rlock3", 4'b0001, 2'd0, 0);

        // Enable low: no grant, rotation preserved
        applyStimulus(0, 0, 4'b1111, 8'h00, 1); checkOutput("en0", 4'b0000, 2'd0, 0);
        applyStimulus(0, 0, 4'b1111, 8'h00, 1); checkOutput("en1", 4'b0000, 2'd0, 0);
        applyStimulus(0, 1, 4'b1111, 8'h00, 1); checkOutput("en2", 4'b0010, 2'd1, 0);
        applyStimulus(0, 1, 4'b1111, 8'h00, 1); checkOutput("en3", 4'b0100, 2'd2, 0);

        @(negedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
